inv_mix_columns_iter: RTL and testbench
=======================================

INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 SHALL have parameter NB, default 4, meaning number of 32-bit columns per state (AES-128 state = 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  state_in holds a valid 128-bit state.
REQ-005 SHALL have port in_ready  output  1  block can accept a state this cycle.
REQ-006 SHALL have port state_in  input  128  input state; column c = bits [127-32c -: 32], row 0 = MSB byte of each column.
REQ-007 SHALL have port out_valid  output  1  state_out holds a finished result.
REQ-008 SHALL have port out_ready  input  1  downstream accepts state_out this cycle.
REQ-009 SHALL have port state_out  output  128  InvMixColumns(state_in), same column/byte layout as state_in.

Function
REQ-010 SHALL implement an FSM with states IDLE, BUSY and DONE; the reset state is IDLE.
REQ-011 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-012 SHALL accept a state on a cycle with in_valid&&in_ready: capture state_in into an internal 128-bit register, clear the 2-bit column counter, and go to BUSY.
REQ-013 SHALL transform exactly one column per BUSY cycle, starting with column 0 and updating it in place.
REQ-014 SHALL compute, for column bytes b0 (MSB)..b3 (LSB) in GF(2^8) mod x^8+x^4+x^3+x+1:
  r0=0e*b0^0b*b1^0d*b2^09*b3; r1=09*b0^0e*b1^0b*b2^0d*b3;
  r2=0d*b0^09*b1^0e*b2^0b*b3; r3=0b*b0^0d*b1^09*b2^0e*b3.
REQ-015 SHALL form the constant multiplies from chained xtime only (x2, x4, x8, then XOR); no lookup tables and no generic multiplier.
REQ-016 SHALL increment the column counter modulo 4 each BUSY cycle, and go to DONE on the cycle that processes column 3.
REQ-017 SHALL assert out_valid exactly 4 cycles after the accept edge; the accept-to-result latency is 4 clocks.
REQ-018 SHALL hold state_out and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-019 SHALL ignore in_valid and state_in while in BUSY or DONE; a new state is accepted only from IDLE, so the first accept after a handshake is one cycle after it.
REQ-020 SHALL drive state_out from the internal register in every state; it is valid only while out_valid=1.
REQ-021 SHALL ignore out_ready outside DONE.

Reset
REQ-022 SHALL, when rst=1 on a clock edge, force the FSM to IDLE, the column counter to 0, the internal state register to 128'h0, out_valid=0 and in_ready=1 on the next cycle.
REQ-023 SHALL, on rst asserted mid-BUSY or in DONE, discard the in-flight state with no partial output; rst has priority over every handshake.

Structure
REQ-024 SHALL take the FSM state enum, the AES reduction constant 8'h1B, and the column width and count constants from a shared package aes_pkg.
REQ-025 SHALL instantiate one combinational sub-module inv_mix_column_word (32-bit in, 32-bit out; REQ-014 per column); only one instance, reused across the four BUSY cycles.

Verification
REQ-026 Bench SHALL cover: state_in with all columns 32'h8e4da1bc, out_ready=1 -> out_valid at accept+4, state_out all columns 32'hdb135345.
REQ-027 Bench SHALL cover: state_in {32'h9fdc589d,32'h01010101,32'hc6c6c6c6,32'h4d7ebdf8} -> state_out {32'hf20a225c,32'h01010101,32'hc6c6c6c6,32'h2d26314c} (checks column order).
REQ-028 Bench SHALL cover: out_ready=0 for 10 cycles in DONE -> out_valid stays 1 and state_out is unchanged; in_valid pulses during this time are not accepted (in_ready=0).
REQ-029 Bench SHALL cover: rst=1 on the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, state_out=128'h0, and no result is produced for that state.
REQ-030 Bench SHALL cover: in_valid held at 1 with three back-to-back states and out_ready=1 -> results in order, each exactly 4 cycles after its accept, with accepts spaced 6 cycles apart.
REQ-031 Bench SHALL cover: round trip with 1000 random states, forward MixColumns (team column module) then this block -> output equals the original state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, GF(2^8) reduction constant, state geometry,
// and the xtime primitive used by the column mixers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         COL_W    = 32;
  localparam int         NUM_COLS = 4;
  localparam int         STATE_W  = COL_W * NUM_COLS;

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column (byte 0 = MSB), built from
// chained xtime only; zero latency, no flow control.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] b   [4];
  logic [7:0] m2  [4];
  logic [7:0] m4  [4];
  logic [7:0] m8  [4];
  logic [7:0] m09 [4];
  logic [7:0] m0b [4];
  logic [7:0] m0d [4];
  logic [7:0] m0e [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]   = col_in[COL_W-1-8*i -: 8];
      m2[i]  = xtime(b[i]);
      m4[i]  = xtime(m2[i]);
      m8[i]  = xtime(m4[i]);
      // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2
      m09[i] = m8[i] ^ b[i];
      m0b[i] = m8[i] ^ m2[i] ^ b[i];
      m0d[i] = m8[i] ^ m4[i] ^ b[i];
      m0e[i] = m8[i] ^ m4[i] ^ m2[i];
    end
  end

  assign col_out[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
  assign col_out[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
  assign col_out[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
  assign col_out[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per cycle through a single shared mixer, result 4 clocks
// after accept; accepts only from IDLE and holds the result in DONE until out_ready.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int NB = NUM_COLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COL_W*NB-1:0]   state_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COL_W*NB-1:0]   state_out
);

  localparam int SW = COL_W * NB;

  fsm_t          fsm_q, fsm_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] data_q, data_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [COL_W-1:0] mix_in;
  logic [COL_W-1:0] mix_out;

  assign mix_in = data_q[SW-1-COL_W*int'(col_q) -: COL_W];

  inv_mix_column_word u_mix (
    .col_in  (mix_in),
    .col_out (mix_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    col_d       = col_q;
    data_d      = data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = state_in;
          col_d      = 2'd0;
          fsm_d      = BUSY;
          in_ready_d = 1'b0;
        end
      end
      BUSY: begin
        // Column is rewritten in place; the counter wraps back to 0 after the last column.
        data_d[SW-1-COL_W*int'(col_q) -: COL_W] = mix_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'(NB - 1)) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        fsm_d       = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      col_q       <= 2'd0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      col_q       <= col_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = data_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and round-trip checks for inv_mix_columns_iter using immediate assertions.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.NB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  // Forward MixColumns reference for the round trip.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  // One transaction with out_ready high: checks latency 4 and the result.
  task automatic xact(input string tag, input logic [127:0] din, input logic [127:0] exp);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    state_in = din;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_early_valid"}, out_valid, 1'b0);
    end
    step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, state_out, exp);
    step();
    chk({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  logic [127:0] st   [3];
  logic [127:0] ex   [3];
  int           acc_cyc [3];
  int           out_cyc [3];
  logic [127:0] held;
  logic [127:0] orig;
  int           cyc, k, nout, n;
  logic         acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_state", state_out, 128'h0);

    xact("uniform", {4{32'h8e4da1bc}}, {4{32'hdb135345}});
    xact("col_order", {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8},
                      {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c});

    // Backpressure in DONE: result holds, new inputs refused.
    out_ready = 1'b0;
    in_valid = 1'b1;
    state_in = {4{32'h8e4da1bc}};
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("hold_valid0", out_valid, 1'b1);
    held = state_out;
    chk("hold_data0", held, {4{32'hdb135345}});
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      state_in = {$urandom, $urandom, $urandom, $urandom};
      chk("hold_in_ready", in_ready, 1'b0);
      step();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", state_out, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_release_valid", out_valid, 1'b0);
    chk("hold_release_ready", in_ready, 1'b1);

    // Reset on the second BUSY cycle discards the state.
    in_valid = 1'b1;
    state_in = {4{32'h8e4da1bc}};
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_state", state_out, 128'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) n++;
    end
    chk("midrst_no_result", n, 0);

    // Back-to-back with in_valid held high.
    st[0] = {4{32'h8e4da1bc}};
    ex[0] = {4{32'hdb135345}};
    st[1] = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8};
    ex[1] = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c};
    st[2] = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h9fdc589d};
    ex[2] = {32'hd4d4d4d5, 32'h2d26314c, 32'hdb135345, 32'hf20a225c};
    cyc = 0; k = 0; nout = 0;
    in_valid = 1'b1;
    state_in = st[0];
    for (int t = 0; t < 40 && nout < 3; t++) begin
      acc = in_ready && (k < 3);
      step();
      cyc++;
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) state_in = st[k];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        out_cyc[nout] = cyc;
        chk("b2b_data", state_out, ex[nout]);
        chk("b2b_latency", out_cyc[nout] - acc_cyc[nout], 4);
        nout++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", nout, 3);
    chk("b2b_spacing01", acc_cyc[1] - acc_cyc[0], 6);
    chk("b2b_spacing12", acc_cyc[2] - acc_cyc[1], 6);
    step();

    // Round trip: forward reference then DUT must restore the original.
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      state_in = fwd_state(orig);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin
        step();
        n++;
      end
      chk("rt_latency", n, 4);
      chk("rt_state", state_out, orig);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
